peripheral_ahb3_ram_slave: RTL and testbench
============================================

Name: peripheral_ahb3_ram_slave

Overview:
- Parametrised AHB3-Lite slave: word-organised RAM target with configurable data width, depth and wait states.
- Adds byte/halfword/word/dword lane writes, range and alignment checking with the two-cycle ERROR response, and read-after-write forwarding.
- Sits behind the AHB3-Lite decoder/mux as a generic on-chip memory or mailbox target for MPSoC tiles and the NoC verification benches.

Parameters:
- HADDR_SIZE, 32: address width.
- HDATA_SIZE, 32: data width; legal values are 32 and 64; BYTES = HDATA_SIZE/8.
- MEM_DEPTH, 256: number of HDATA_SIZE words; need not be a power of 2.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted per OKAY data phase; range 0..15.

Ports:
- HCLK, in, 1: clock; all state changes on the rising edge.
- HRESET, in, 1: asynchronous, active-high reset.
- HSEL, in, 1: slave select from the decoder.
- HADDR, in, HADDR_SIZE: byte address, relative to the slave base.
- HWDATA, in, HDATA_SIZE: write data, valid in the data phase.
- HRDATA, out, HDATA_SIZE: read data.
- HWRITE, in, 1: 1 = write.
- HSIZE, in, 3: transfer size, log2 of bytes.
- HBURST, in, 3: burst type; ignored, every beat is addressed independently.
- HPROT, in, 4: protection; ignored.
- HTRANS, in, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HMASTLOCK, in, 1: locked transfer; ignored.
- HREADY, in, 1: bus ready from the mux.
- HREADYOUT, out, 1: slave ready.
- HRESP, out, 1: 0 = OKAY, 1 = ERROR.

Behaviour:
- Reset: one clock, HCLK; reset HRESET is asynchronous and active-high.
  - On assertion: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, captured address-phase registers cleared.
  - RAM contents are not reset.
  - Asserting HRESET mid data phase aborts the transfer immediately; a pending write is not committed.
- Address-phase acceptance: on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1.
  - Captured: HADDR, HWRITE, HSIZE.
  - Error check:
    - ERR if HSIZE > log2(BYTES);
    - ERR if HADDR is not aligned to 2^HSIZE;
    - ERR if HADDR >= MEM_DEPTH*BYTES.
  - With HSEL=0, IDLE or BUSY, no transfer is captured; the next data phase is a zero-wait OKAY.
- FSM states and transitions:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted OK transfer -> DATA (WAIT_STATES>0) or COMPLETE behaviour in the next cycle (WAIT_STATES=0).
    - Accepted ERR transfer -> ERR1.
  - DATA: HREADYOUT=0, HRESP=0; counter counts up to WAIT_STATES, then the final cycle drives HREADYOUT=1.
    - New acceptance in that final cycle follows the IDLE rules (back-to-back pipelining).
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. An address phase presented here is accepted normally; the master may have driven IDLE instead.
- Data-phase latency: 1+WAIT_STATES cycles from address-phase acceptance to the HREADYOUT=1 cycle.
  - Errored transfers always take 2 cycles, independent of WAIT_STATES.
- Writes:
  - HWDATA is sampled on the completing edge (HREADYOUT=1) only.
  - Byte enables are 2^HSIZE contiguous lanes starting at HADDR[log2(BYTES)-1:0], little-endian.
  - Only enabled bytes of word HADDR/BYTES change.
  - Errored writes never modify the RAM.
- Reads:
  - HRDATA carries the full addressed word during the completing cycle; the master extracts the lanes.
  - HRDATA holds its last value outside read data phases.
  - Errored reads leave HRDATA unchanged.
- Read-after-write forwarding: a read address phase that overlaps the data phase of a write to the same word returns the merged word.
  - Write-enabled bytes come from that HWDATA; the remaining bytes come from the RAM.
  - This must hold for every WAIT_STATES value.
- Simultaneous events: HRESET overrides everything. HSEL dropping during a wait state does not cancel the in-flight data phase.

Test Plan:
- Reset/idle: assert HRESET 3 cycles with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, HRDATA=0; IDLE transfers -> zero-wait OKAY with no RAM change.
- Word write/read, HDATA_SIZE=32, WAIT_STATES=0: write 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF one cycle after the read address phase, HREADYOUT never low.
- Byte lanes: write word 0x00000000 @0x20, byte 0xAA @0x21, halfword 0x5566 @0x22, then read @0x20 -> 0x5566AA00.
- Wait states, WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles then high; back-to-back NONSEQ pair -> 8 cycles total from first acceptance.
- Errors, MEM_DEPTH=256, HDATA_SIZE=32:
  - write @0x400 -> HRESP=1 for 2 cycles (HREADYOUT 0 then 1);
  - HSIZE=2 @0x02 -> ERROR;
  - HSIZE=3 -> ERROR;
  - subsequent read of word 0 -> unchanged.
- Forwarding and reset mid-op, WAIT_STATES=0:
  - word 0x30 holds 0x11223344; pipelined write byte 0x99 @0x30 followed by read @0x30 -> 0x11223399.
  - With WAIT_STATES=2, assert HRESET during a write wait state -> word unchanged, HREADYOUT=1.

Source files
------------

// File: rtl/peripheral_ahb3_ram_slave.sv
// AHB3-Lite RAM target: word-organised memory with byte-lane writes, configurable
// wait states, two-cycle ERROR response for bad accesses and read-after-write forwarding.
module peripheral_ahb3_ram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES = HDATA_SIZE / 8;
  localparam int BL    = $clog2(BYTES);
  localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam longint unsigned MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready;
  logic                  accept;
  logic                  req_err;
  logic [2:0]            amask;
  logic [HADDR_SIZE-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  commit;
  logic                  fwd_hit;
  logic [AW-1:0]         rd_idx, wr_idx;
  logic [BYTES-1:0]      wr_be;
  logic [HDATA_SIZE-1:0] wr_mask;
  logic [HDATA_SIZE-1:0] rd_word;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
  logic                  unused_ok;

  // Contiguous little-endian lanes covered by a transfer of 2^size bytes at offset.
  function automatic logic [BYTES-1:0] lane_enables(input logic [2:0] size,
                                                    input logic [BL-1:0] offset);
    logic [BYTES-1:0] be;
    int               n;
    n  = 1 << size;
    be = '0;
    for (int i = 0; i < BYTES; i++)
      be[i] = (i >= int'(offset)) && (i < int'(offset) + n);
    return be;
  endfunction

  always_comb begin
    case (HSIZE)
      3'd0:    amask = 3'b000;
      3'd1:    amask = 3'b001;
      3'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end

  assign accept  = HSEL && HREADY && HTRANS[1];
  assign req_err = (HSIZE > 3'(BL)) || (|(HADDR[2:0] & amask)) || (64'(HADDR) >= MEM_BYTES);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    HRESP   = 1'b0;
    unique case (state_q)
      ST_DATA: begin
        ready = (cnt_q == WS);
        if (cnt_q != WS) cnt_d = cnt_q + 4'd1;
        else             state_d = ST_IDLE;
      end
      ST_ERR1: begin
        ready   = 1'b0;
        HRESP   = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ready && accept) begin
      state_d = req_err ? ST_ERR1 : ST_DATA;
      cnt_d   = '0;
    end
  end

  assign HREADYOUT = ready;

  assign commit  = (state_q == ST_DATA) && ready && write_q;
  assign rd_idx  = HADDR[BL +: AW];
  assign wr_idx  = addr_q[BL +: AW];
  assign wr_be   = lane_enables(size_q, addr_q[BL-1:0]);
  assign fwd_hit = commit && (wr_idx == rd_idx);

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < BYTES; i++)
      wr_mask[8*i +: 8] = {8{wr_be[i]}};
  end

  // A read accepted on the edge that commits a write to the same word sees the new lanes.
  assign rd_word = fwd_hit ? ((mem[rd_idx] & ~wr_mask) | (HWDATA & wr_mask)) : mem[rd_idx];

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      HRDATA  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ready && accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE && !req_err;
        size_q  <= HSIZE;
        if (!HWRITE && !req_err) HRDATA <= rd_word;
      end
    end
  end

  // NOTE: the array has no reset; clearing it would forbid RAM inference and its contents are undefined by design.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < BYTES; i++)
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], addr_q};

endmodule

// File: tb/tb_peripheral_ahb3_ram_slave.sv
// Bench for peripheral_ahb3_ram_slave: three slaves (0, 3 and 2 wait states) share one
// address/data bus; a pipelined master feeds a scoreboard checked at every completing data phase.
module tb_peripheral_ahb3_ram_slave;

  localparam int NS    = 3;
  localparam int BOUND = 100;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        rd;
    logic        resp;
    logic [31:0] data;
  } exp_t;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [NS-1:0] hsel;
  logic [31:0]   haddr;
  logic [31:0]   hwdata;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [1:0]    htrans;
  logic          hmastlock;
  logic [31:0]   hrdata [NS];
  logic [NS-1:0] hreadyout;
  logic [NS-1:0] hresp;

  beat_t       q_beats[$];
  exp_t        sb[$];
  logic [7:0]  model [NS][1024];
  int          n_vec = 0;
  int          n_err = 0;
  int          last_lat;
  int          last_busy;
  logic [31:0] last_rd;

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < NS; g++) begin : g_slv
    peripheral_ahb3_ram_slave #(
      .HADDR_SIZE (32),
      .HDATA_SIZE (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
    ) dut (
      .HCLK     (hclk),
      .HRESET   (hreset),
      .HSEL     (hsel[g]),
      .HADDR    (haddr),
      .HWDATA   (hwdata),
      .HRDATA   (hrdata[g]),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HBURST   (hburst),
      .HPROT    (hprot),
      .HTRANS   (htrans),
      .HMASTLOCK(hmastlock),
      .HREADY   (hreadyout[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    beat_t b;
    b = '{wr, addr, size, wdata};
    q_beats.push_back(b);
  endtask

  // Byte-addressed reference: decides the response and updates/reads the model.
  task automatic predict(input int s, input beat_t b, output exp_t e);
    int n;
    int a;
    n      = 1 << b.size;
    a      = int'(b.addr);
    e.rd   = !b.wr;
    e.resp = (b.size > 3'd2) || (a % n != 0) || (a >= 1024);
    e.data = '0;
    if (!e.resp) begin
      if (b.wr) begin
        for (int i = 0; i < n; i++) model[s][a + i] = b.wdata[8*((a + i) % 4) +: 8];
      end else begin
        for (int i = 0; i < 4; i++) e.data[8*i +: 8] = model[s][(a & ~3) + i];
      end
    end
  endtask

  // Issues every queued beat back to back to slave s; entered and left just after a rising edge.
  task automatic run(input int s);
    beat_t dp, acc;
    exp_t  e;
    bit    dp_valid    = 1'b0;
    bit    acc_pending = 1'b0;
    int    cyc         = 0;
    int    first_acc   = -1;
    int    done_cyc    = 0;
    logic  rdy;
    last_busy = 0;
    while ((q_beats.size() > 0 || acc_pending || dp_valid) && cyc < BOUND) begin
      rdy = hreadyout[s];
      if (acc_pending) begin
        dp          = acc;
        dp_valid    = 1'b1;
        acc_pending = 1'b0;
      end
      hwdata = (dp_valid && dp.wr) ? dp.wdata : 32'h0;
      if (!rdy) last_busy++;
      if (dp_valid) begin
        e = sb[0];
        check($sformatf("s%0d hresp @0x%0h", s, dp.addr), 32'(hresp[s]), 32'(e.resp));
        if (rdy) begin
          void'(sb.pop_front());
          if (e.rd && !e.resp) begin
            check($sformatf("s%0d hrdata @0x%0h", s, dp.addr), hrdata[s], e.data);
            last_rd = hrdata[s];
          end
          dp_valid = 1'b0;
          done_cyc = cyc;
        end
      end
      hsel    = '0;
      hsel[s] = 1'b1;
      if (q_beats.size() > 0) begin
        htrans = 2'b10;
        haddr  = q_beats[0].addr;
        hwrite = q_beats[0].wr;
        hsize  = q_beats[0].size;
        if (rdy) begin
          acc = q_beats.pop_front();
          predict(s, acc, e);
          sb.push_back(e);
          acc_pending = 1'b1;
          if (first_acc < 0) first_acc = cyc;
        end
      end else begin
        htrans = 2'b00;
        hwrite = 1'b0;
      end
      @(posedge hclk);
      #1;
      cyc++;
    end
    check($sformatf("s%0d run finished in bound", s), 32'(cyc < BOUND), 32'd1);
    last_lat = done_cyc - first_acc;
    hsel     = '0;
    htrans   = 2'b00;
    hwrite   = 1'b0;
    hwdata   = '0;
    q_beats.delete();
    sb.delete();
  endtask

  // Non-transfer cycles with write-looking control: must stay zero-wait OKAY.
  task automatic idle_cycles(input int s, input int n, input logic [1:0] trans);
    for (int i = 0; i < n; i++) begin
      hsel    = '0;
      hsel[s] = (i % 2 == 0);
      htrans  = trans;
      hwrite  = 1'b1;
      haddr   = 32'h10;
      hsize   = 3'd2;
      hwdata  = 32'h0;
      @(posedge hclk);
      #1;
      check($sformatf("s%0d idle hreadyout", s), 32'(hreadyout[s]), 32'd1);
      check($sformatf("s%0d idle hresp", s), 32'(hresp[s]), 32'd0);
    end
    hsel   = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  initial begin
    hreset    = 1'b1;
    hsel      = '1;
    htrans    = 2'b10;
    haddr     = 32'h0;
    hwrite    = 1'b0;
    hsize     = 3'd2;
    hwdata    = 32'h0;
    hburst    = 3'd0;
    hprot     = 4'd0;
    hmastlock = 1'b0;

    // Reset held three cycles with NONSEQ on the bus.
    repeat (3) @(posedge hclk);
    #1;
    for (int s = 0; s < NS; s++) begin
      check($sformatf("s%0d reset hreadyout", s), 32'(hreadyout[s]), 32'd1);
      check($sformatf("s%0d reset hresp", s), 32'(hresp[s]), 32'd0);
      check($sformatf("s%0d reset hrdata", s), hrdata[s], 32'h0);
    end
    hsel   = '0;
    htrans = 2'b00;
    hreset = 1'b0;
    @(posedge hclk);
    #1;

    idle_cycles(0, 3, 2'b00);
    idle_cycles(1, 3, 2'b01);

    // Word write then read, no wait states; idle/busy write-looking cycles in between.
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    run(0);
    check("ws0 write latency", 32'(last_lat), 32'd1);
    idle_cycles(0, 2, 2'b00);
    idle_cycles(0, 2, 2'b01);
    push(1'b0, 32'h10, 3'd2, 32'h0);
    run(0);
    check("ws0 read data", last_rd, 32'hDEADBEEF);
    check("ws0 read latency", 32'(last_lat), 32'd1);
    check("ws0 read never stalled", 32'(last_busy), 32'd0);

    // Byte lanes, issued back to back.
    push(1'b1, 32'h20, 3'd2, 32'h00000000);
    push(1'b1, 32'h21, 3'd0, 32'h0000AA00);
    push(1'b1, 32'h22, 3'd1, 32'h55660000);
    push(1'b0, 32'h20, 3'd2, 32'h0);
    run(0);
    check("byte lane merge", last_rd, 32'h5566AA00);

    // Wait states on slave 1.
    push(1'b1, 32'h0, 3'd2, 32'hA5A50001);
    push(1'b1, 32'h4, 3'd2, 32'hA5A50002);
    run(1);
    push(1'b0, 32'h0, 3'd2, 32'h0);
    run(1);
    check("ws3 single read latency", 32'(last_lat), 32'd4);
    check("ws3 single read low cycles", 32'(last_busy), 32'd3);
    push(1'b0, 32'h0, 3'd2, 32'h0);
    push(1'b0, 32'h4, 3'd2, 32'h0);
    run(1);
    check("ws3 pair total cycles", 32'(last_lat), 32'd8);
    check("ws3 pair low cycles", 32'(last_busy), 32'd6);
    check("ws3 pair second data", last_rd, 32'hA5A50002);

    // Error responses.
    push(1'b1, 32'h0, 3'd2, 32'h01020304);
    run(0);
    push(1'b1, 32'h400, 3'd2, 32'hFFFFFFFF);
    run(0);
    check("range err latency", 32'(last_lat), 32'd2);
    check("range err low cycles", 32'(last_busy), 32'd1);
    push(1'b1, 32'h2, 3'd2, 32'hFFFFFFFF);
    run(0);
    check("misalign err latency", 32'(last_lat), 32'd2);
    push(1'b1, 32'h0, 3'd3, 32'hFFFFFFFF);
    run(0);
    check("size err latency", 32'(last_lat), 32'd2);
    push(1'b0, 32'h0, 3'd2, 32'h0);
    run(0);
    check("word 0 after errors", last_rd, 32'h01020304);
    push(1'b0, 32'h400, 3'd2, 32'h0);
    run(1);
    check("ws3 err latency", 32'(last_lat), 32'd2);
    push(1'b1, 32'h3FC, 3'd2, 32'h0BADCAFE);
    push(1'b0, 32'h3FC, 3'd2, 32'h0);
    run(0);
    check("last word", last_rd, 32'h0BADCAFE);

    // Read-after-write forwarding with and without wait states.
    push(1'b1, 32'h30, 3'd2, 32'h11223344);
    run(0);
    push(1'b1, 32'h30, 3'd0, 32'h00000099);
    push(1'b0, 32'h30, 3'd2, 32'h0);
    run(0);
    check("ws0 forwarding", last_rd, 32'h11223399);
    push(1'b1, 32'h30, 3'd2, 32'h11223344);
    run(1);
    push(1'b1, 32'h33, 3'd0, 32'h77000000);
    push(1'b0, 32'h30, 3'd2, 32'h0);
    run(1);
    check("ws3 forwarding", last_rd, 32'h77223344);

    // Reset during a write wait state on slave 2.
    push(1'b1, 32'h40, 3'd2, 32'h12345678);
    run(2);
    check("ws2 write latency", 32'(last_lat), 32'd3);
    hsel    = '0;
    hsel[2] = 1'b1;
    htrans  = 2'b10;
    haddr   = 32'h40;
    hwrite  = 1'b1;
    hsize   = 3'd2;
    @(posedge hclk);
    #1;
    hsel   = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = 32'hCAFEF00D;
    check("ws2 in wait state", 32'(hreadyout[2]), 32'd0);
    #2;
    hreset = 1'b1;
    #1;
    check("mid-op reset hreadyout", 32'(hreadyout[2]), 32'd1);
    check("mid-op reset hresp", 32'(hresp[2]), 32'd0);
    check("mid-op reset hrdata", hrdata[2], 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    hwdata = 32'h0;
    push(1'b0, 32'h40, 3'd2, 32'h0);
    run(2);
    check("aborted write not committed", last_rd, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
